// File: rtl/shift_sequencer_pkg.sv
// Shared op codes and state encodings for shift_sequencer and its shifter.
package shift_sequencer_pkg;

  localparam logic [2:0] OP_SHIFT_LEFT_ZERO  = 3'd0;
  localparam logic [2:0] OP_SHIFT_RIGHT_ZERO = 3'd1;
  localparam logic [2:0] OP_SHIFT_LEFT_ONE   = 3'd2;
  localparam logic [2:0] OP_SHIFT_RIGHT_ONE  = 3'd3;
  localparam logic [2:0] OP_ROTATE_LEFT      = 3'd4;
  localparam logic [2:0] OP_ROTATE_RIGHT     = 3'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Right-moving ops eject bit 0; all others (including no-ops) report the MSB.
  function automatic logic is_right_op(logic [2:0] op);
    return (op == OP_SHIFT_RIGHT_ZERO) || (op == OP_SHIFT_RIGHT_ONE) ||
           (op == OP_ROTATE_RIGHT);
  endfunction

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Combinational single-position shifter/rotator; op codes 6-7 pass data through.
module shift_sequencer_shifter
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [2:0]            i_op,
  output logic [DATA_WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_op)
      OP_SHIFT_LEFT_ZERO:  o_data = {i_data[DATA_WIDTH-2:0], 1'b0};
      OP_SHIFT_RIGHT_ZERO: o_data = {1'b0, i_data[DATA_WIDTH-1:1]};
      OP_SHIFT_LEFT_ONE:   o_data = {i_data[DATA_WIDTH-2:0], 1'b1};
      OP_SHIFT_RIGHT_ONE:  o_data = {1'b1, i_data[DATA_WIDTH-1:1]};
      OP_ROTATE_LEFT:      o_data = {i_data[DATA_WIDTH-2:0], i_data[DATA_WIDTH-1]};
      OP_ROTATE_RIGHT:     o_data = {i_data[0], i_data[DATA_WIDTH-1:1]};
      default:             o_data = i_data;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate engine: one shifter step per clock for a programmed count.
// Optional macro SHIFT_SEQUENCER_SERIAL_IN_EN fills vacated bits of ops 0-3 from i_serial_in.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [2:0]            i_op,
  input  logic [CNT_WIDTH-1:0]  i_count,
  input  logic                  i_serial_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_serial_out
);

  logic [1:0]            r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic [2:0]            r_op, w_op_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic                  r_sout, w_sout_nxt;

  logic [CNT_WIDTH-1:0]  w_count_sat;
  logic [DATA_WIDTH-1:0] w_shift_out;
  logic [DATA_WIDTH-1:0] w_step;

  assign w_count_sat = (i_count > CNT_WIDTH'(DATA_WIDTH)) ? CNT_WIDTH'(DATA_WIDTH) : i_count;

  shift_sequencer_shifter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shifter (
    .i_data (r_data),
    .i_op   (r_op),
    .o_data (w_shift_out)
  );

`ifdef SHIFT_SEQUENCER_SERIAL_IN_EN
  always_comb begin
    w_step = w_shift_out;
    case (r_op)
      OP_SHIFT_LEFT_ZERO, OP_SHIFT_LEFT_ONE:   w_step[0] = i_serial_in;
      OP_SHIFT_RIGHT_ZERO, OP_SHIFT_RIGHT_ONE: w_step[DATA_WIDTH-1] = i_serial_in;
      default: ;
    endcase
  end
`else
  logic w_unused_serial_in;
  assign w_unused_serial_in = i_serial_in;
  assign w_step = w_shift_out;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    w_sout_nxt  = r_sout;
    // Abort outranks everything; the register keeps its partial value.
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_data_nxt  = i_data;
            w_op_nxt    = i_op;
            w_cnt_nxt   = w_count_sat;
            w_state_nxt = (w_count_sat != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          w_data_nxt = w_step;
          w_sout_nxt = is_right_op(r_op) ? r_data[0] : r_data[DATA_WIDTH-1];
          w_cnt_nxt  = r_cnt - CNT_WIDTH'(1);
          if (r_cnt == CNT_WIDTH'(1)) begin
            w_state_nxt = ST_DONE;
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_sout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_op    <= w_op_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sout  <= w_sout_nxt;
    end
  end

  assign o_busy       = (r_state == ST_SHIFT) || (r_state == ST_DONE);
  assign o_done       = (r_state == ST_DONE);
  assign o_data       = r_data;
  assign o_serial_out = r_sout;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes expected results, a monitor checks o_done.
module tb_shift_sequencer;

  localparam int W  = 8;
  localparam int CW = 4;
`ifdef SHIFT_SEQUENCER_SERIAL_IN_EN
  localparam logic [W-1:0] SerialExp = 8'b0000_0101;
`else
  localparam logic [W-1:0] SerialExp = 8'h00;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          sin = 1'b0;
  logic [W-1:0]  din = '0;
  logic [2:0]    op = '0;
  logic [CW-1:0] cnt = '0;
  logic          busy, done, sout;
  logic [W-1:0]  dout;

  shift_sequencer #(
    .DATA_WIDTH (W),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_data       (din),
    .i_op         (op),
    .i_count      (cnt),
    .i_serial_in  (sin),
    .o_busy       (busy),
    .o_done       (done),
    .o_data       (dout),
    .o_serial_out (sout)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges++;

  typedef struct {
    logic [W-1:0] data;
    int           edge_no;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got pulse with o_data=%0h at edge %0d, expected none",
                 dout, edges);
      end else begin
        e = sb.pop_front();
        check("done_data", 32'(dout), 32'(e.data));
        check("done_edge", 32'(edges), 32'(e.edge_no));
      end
    end
  end

  // Called #1 after a posedge; start is sampled at the next edge (E0).
  task automatic issue(input logic [W-1:0] d, input logic [2:0] o, input logic [CW-1:0] c,
                       input logic [W-1:0] expd, input bit expect_done);
    int n;
    n = (int'(c) > W) ? W : int'(c);
    din = d;
    op = o;
    cnt = c;
    start = 1'b1;
    if (expect_done) sb.push_back('{expd, edges + 1 + n});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 50);
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles, expected 0", n);
    end
  endtask

  typedef struct {
    logic [W-1:0]  d;
    logic [2:0]    o;
    logic [CW-1:0] c;
    logic [W-1:0]  e;
  } vec_t;

  initial begin
    vec_t vecs[$];
    logic [2:0] rot_sout;
    vecs.push_back('{8'h80, 3'd1, 4'd3, 8'h10});
    vecs.push_back('{8'h00, 3'd2, 4'd2, 8'h03});
    vecs.push_back('{8'h01, 3'd5, 4'd1, 8'h80});
    vecs.push_back('{8'h3C, 3'd7, 4'd4, 8'h3C});
    vecs.push_back('{8'h96, 3'd6, 4'd2, 8'h96});

    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_data", 32'(dout), 0);
    check("rst_sout", 32'(sout), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero count completes straight away; no bit leaves the register.
    issue(8'h5A, 3'd0, 4'd0, 8'h5A, 1'b1);
    wait_idle();
    check("zero_sout", 32'(sout), 0);

    // Rotate left with per-step serial output and busy window.
    rot_sout = 3'b101;
    @(posedge clk);
    #1 issue(8'b1010_0011, 3'd4, 4'd3, 8'b0001_1101, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rol_busy", 32'(busy), 1);
      if (i > 0) check("rol_sout", 32'(sout), 32'(rot_sout[i-1]));
    end
    @(negedge clk);
    check("rol_idle_busy", 32'(busy), 0);
    check("rol_idle_data", 32'(dout), 32'(8'b0001_1101));

    // Shift right with ones; count 15 saturates to 8.
    @(posedge clk);
    #1 issue(8'h00, 3'd3, 4'd8, 8'hFF, 1'b1);
    wait_idle();
    @(posedge clk);
    #1 issue(8'h00, 3'd3, 4'd15, 8'hFF, 1'b1);
    wait_idle();

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 issue(vecs[i].d, vecs[i].o, vecs[i].c, vecs[i].e, 1'b1);
      wait_idle();
    end

    // Start during SHIFT is ignored.
    @(posedge clk);
    #1 issue(8'h01, 3'd0, 4'd5, 8'h20, 1'b1);
    @(posedge clk);
    #1 begin
      din = 8'hAA; op = 3'd1; cnt = 4'd1; start = 1'b1;
    end
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    check("ign_data", 32'(dout), 32'(8'h20));

    // Abort mid-operation keeps the partial value and never pulses done.
    @(posedge clk);
    #1 issue(8'h01, 3'd0, 4'd5, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_data", 32'(dout), 32'(8'h04));
    repeat (8) @(negedge clk);

    // Abort in IDLE blocks a simultaneous start.
    @(posedge clk);
    #1 begin
      din = 8'hFF; op = 3'd0; cnt = 4'd1; start = 1'b1; abort = 1'b1;
    end
    @(posedge clk);
    #1 begin
      start = 1'b0; abort = 1'b0;
    end
    @(negedge clk);
    check("idle_abort_busy", 32'(busy), 0);
    check("idle_abort_data", 32'(dout), 32'(8'h04));

    // Asynchronous reset mid-operation.
    @(posedge clk);
    #1 issue(8'hC3, 3'd4, 4'd4, 8'h00, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_data", 32'(dout), 0);
    check("midrst_sout", 32'(sout), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 issue(8'h81, 3'd0, 4'd1, 8'h02, 1'b1);
    wait_idle();
    check("post_rst_sout", 32'(sout), 1);

    // Serial fill on shift-left-zero.
    @(posedge clk);
    #1 sin = 1'b1;
    issue(8'h00, 3'd0, 4'd3, SerialExp, 1'b1);
    @(posedge clk);
    #1 sin = 1'b0;
    @(posedge clk);
    #1 sin = 1'b1;
    wait_idle();
    sin = 1'b0;

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift/rotate engine. Holds a DATA_WIDTH-bit working register and applies one shifter operation per clock for a programmed number of steps.
- Sits directly upstream of the combinational shifter. Its register drives shifter i_data, and shifter o_data is written back each step.
- Used by the serial peripheral path and by bit-manipulation microcode that needs N-position shifts or rotates.

Parameters:
- DATA_WIDTH, 8, width of the working register and data ports (minimum 2).
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, width of the step counter; must be able to hold the value DATA_WIDTH.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_start  input  1  request a new operation; sampled only in IDLE.
- i_abort  input  1  synchronous cancel; returns to IDLE with no o_done pulse.
- i_data  input  DATA_WIDTH  load value, captured on an accepted start.
- i_op  input  3  shifter op code: 0 SLZ, 1 SRZ, 2 SLO, 3 SRO, 4 ROL, 5 ROR, 6-7 no-op. Captured on start.
- i_count  input  CNT_WIDTH  number of steps; values above DATA_WIDTH are saturated to DATA_WIDTH. Captured on start.
- i_serial_in  input  1  serial fill bit; used only with the optional feature.
- o_busy  output  1  high in SHIFT and DONE.
- o_done  output  1  one-cycle pulse when the result is valid.
- o_data  output  DATA_WIDTH  working register contents.
- o_serial_out  output  1  last bit shifted or rotated out.

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - state = IDLE;
  - working register, latched op and step counter = 0;
  - o_busy = 0, o_done = 0, o_data = 0, o_serial_out = 0.
- States: IDLE, SHIFT, DONE. Encoding is 2 bits.
- IDLE:
  - i_start=1 at edge T: load register <= i_data, op <= i_op, counter <= min(i_count, DATA_WIDTH).
  - Next state is SHIFT if the loaded count is nonzero, otherwise DONE.
- SHIFT: each edge does the following.
  - register <= shifter(register, op).
  - o_serial_out <= register[DATA_WIDTH-1] for ops 0, 2, 4, and 6-7; register[0] for ops 1, 3, 5.
  - counter decrements; when it reaches 0 the next state is DONE.
- DONE: o_done=1 for exactly this one cycle; unconditional return to IDLE at the next edge.
- Latency: o_done is asserted during cycle T+count+1, with o_data final in that same cycle.
- o_data remains valid and stable in IDLE until the next accepted start.
- i_start in SHIFT/DONE is ignored (no queueing). i_start in the DONE cycle is also ignored; a new start is accepted only from IDLE.
- i_abort has priority over every transition except reset.
  - In SHIFT or DONE: next state IDLE, no o_done pulse, register keeps its current partial value.
  - In IDLE it also blocks i_start in the same cycle.
- Ops 6-7: the register is unchanged each step, but the counter still runs and o_done still pulses.
- Asynchronous reset mid-operation: immediate return to the reset values; no o_done pulse.

Optional Feature:
- Macro: SHIFT_SEQUENCER_SERIAL_IN_EN.
- Defined: for ops 0-3 the vacated bit (LSB for left ops, MSB for right ops) takes i_serial_in sampled at that step's edge, instead of the 0/1 pad. Rotates and no-ops are unaffected. With op 0 this gives a shift-register serializer/deserializer.
- Undefined: i_serial_in is unused and the shifter output is written back unmodified.

Decomposition:
- Shared package holds:
  - op-code localparams (OP_SHIFT_LEFT_ZERO .. OP_ROTATE_RIGHT, matching the shifter);
  - state encodings ST_IDLE/ST_SHIFT/ST_DONE.
- One sub-module: an instance of the existing combinational shifter (DATA_WIDTH passed through), fed by the working register and latched op.
- Serial-in override is a small mux after the shifter output, inside shift_sequencer. No new sub-module for it.

Test Plan:
- Rotate left: i_data=8'b1010_0011, i_op=4, i_count=3, start at T.
  - o_serial_out sequence 1,0,1 at T+1..T+3.
  - o_done at T+4 with o_data=8'b0001_1101.
  - o_busy high T+1..T+4.
- Shift right with one padding: i_data=8'h00, i_op=3, i_count=8 -> o_data=8'hFF at o_done (T+9). i_count=15 saturates to 8 and gives the same result and timing.
- Zero count: i_count=0, i_data=8'h5A, i_op=0 -> o_done at T+1, o_data=8'h5A, o_serial_out stays 0.
- Busy and abort:
  - i_start pulsed at T+2 during a count-5 op is ignored; o_done occurs only at T+6.
  - i_abort at T+3 returns to IDLE at T+4 with no o_done.
- Reset mid-operation: i_reset_n low at T+2 of a count-4 op -> o_busy, o_done, o_data and o_serial_out all 0 immediately; the next start works normally.
- With SHIFT_SEQUENCER_SERIAL_IN_EN: i_data=8'h00, i_op=0, i_count=3, i_serial_in=1,0,1 -> o_data=8'b0000_0101 at o_done.
